// File: rtl/rob_multiport_pkg.sv
// Shared definitions for the multi-port reorder buffer.
//
// Core-level defaults, usable as macros by code that predates the package:
//   `PR_ADDR_W       physical register address width
//   `ROB_DATA_W      payload width: old-alias pair plus valid bit (2*`PR_ADDR_W+1)
//   `ROB_ELEMENTS    entry count
//   `ROB_PUSH_WIDTH  entries allocated per cycle
//   `ROB_POP_WIDTH   entries retired per cycle
//   `ROB_CMPLT_PORTS completion report ports (arith, mem, term)
// The package mirrors them as localparams for parameter defaults.

`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif
`ifndef ROB_DATA_W
`define ROB_DATA_W (2*`PR_ADDR_W+1)
`endif
`ifndef ROB_ELEMENTS
`define ROB_ELEMENTS 16
`endif
`ifndef ROB_PUSH_WIDTH
`define ROB_PUSH_WIDTH 4
`endif
`ifndef ROB_POP_WIDTH
`define ROB_POP_WIDTH 3
`endif
`ifndef ROB_CMPLT_PORTS
`define ROB_CMPLT_PORTS 3
`endif

package rob_multiport_pkg;
    localparam int unsigned ROB_DATA_W_DEF  = `ROB_DATA_W;
    localparam int unsigned ROB_ELEMS_DEF   = `ROB_ELEMENTS;
    localparam int unsigned ROB_PUSH_W_DEF  = `ROB_PUSH_WIDTH;
    localparam int unsigned ROB_POP_W_DEF   = `ROB_POP_WIDTH;
    localparam int unsigned ROB_CMPLT_P_DEF = `ROB_CMPLT_PORTS;
endpackage

// File: rtl/rob_commit_scan.sv
// Retire-window scan: counts the run of completed entries starting at head.
//
// Ports:
//   done_rot       in   done bits of the first POP_WIDTH entries from head (bit 0 = head)
//   count          in   current occupancy (0..ELEMENTS)
//   dout_valid_ct  out  leading-ones length, limited by count and POP_WIDTH

module rob_commit_scan #(
    parameter int unsigned POP_WIDTH = 3,
    parameter int unsigned IDX_W     = 4
) (
    input  logic [POP_WIDTH-1:0]       done_rot,
    input  logic [IDX_W:0]             count,
    output logic [$clog2(POP_WIDTH):0] dout_valid_ct
);
    localparam int unsigned CT_W  = $clog2(POP_WIDTH) + 1;
    localparam int unsigned PTR_W = IDX_W + 1;

    logic run;

    always_comb begin
        dout_valid_ct = '0;
        run           = 1'b1;
        for (int unsigned i = 0; i < POP_WIDTH; i++) begin
            // Done bits past the tail may be stale, so occupancy bounds the run.
            if (run && done_rot[i] && (PTR_W'(i) < count)) begin
                dout_valid_ct = dout_valid_ct + CT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer: in-order allocation, out-of-order completion,
// in-order retirement with count-based handshakes.
//
// Optional feature macro: ROB_FLUSH_EN adds flush/flush_entry (tail squash).
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   din             PUSH_WIDTH payload lanes, lane 0 oldest
//   din_valid_ct    number of valid push lanes
//   din_ready_ct    min(PUSH_WIDTH, free entries), from registered state only
//   entry_nums      index lane i receives if pushed this cycle
//   dout            POP_WIDTH retiring payloads, lane 0 = head
//   dout_valid_ct   completed run length from head, capped at POP_WIDTH
//   dout_ready_ct   consumer capacity this cycle
//   completed       CMPLT_PORTS completing entry indices
//   cmplt_valid     per-port completion strobe
//   flush           squash everything younger than flush_entry (ROB_FLUSH_EN)
//   flush_entry     last surviving entry (ROB_FLUSH_EN)

module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = ROB_DATA_W_DEF,
    parameter int unsigned PUSH_WIDTH  = ROB_PUSH_W_DEF,
    parameter int unsigned POP_WIDTH   = ROB_POP_W_DEF,
    parameter int unsigned CMPLT_PORTS = ROB_CMPLT_P_DEF,
    parameter int unsigned ELEMENTS    = ROB_ELEMS_DEF,
    parameter int unsigned IDX_W       = $clog2(ELEMENTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PUSH_WIDTH*DATA_WIDTH-1:0]  din,
    input  logic [$clog2(PUSH_WIDTH):0]       din_valid_ct,
    output logic [$clog2(PUSH_WIDTH):0]       din_ready_ct,
    output logic [PUSH_WIDTH*IDX_W-1:0]       entry_nums,
    output logic [POP_WIDTH*DATA_WIDTH-1:0]   dout,
    output logic [$clog2(POP_WIDTH):0]        dout_valid_ct,
    input  logic [$clog2(POP_WIDTH):0]        dout_ready_ct,
    input  logic [CMPLT_PORTS*IDX_W-1:0]      completed,
    input  logic [CMPLT_PORTS-1:0]            cmplt_valid
`ifdef ROB_FLUSH_EN
    ,
    input  logic                              flush,
    input  logic [IDX_W-1:0]                  flush_entry
`endif
);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned PV_W  = $clog2(PUSH_WIDTH) + 1;
    localparam int unsigned PC_W  = $clog2(POP_WIDTH) + 1;

    // head/tail carry a wrap bit so count = tail - head spans 0..ELEMENTS.
    logic [PTR_W-1:0]      head, tail, tail_nxt;
    logic [PTR_W-1:0]      count, free_ct;
    logic [IDX_W-1:0]      head_idx, tail_idx;
    logic [ELEMENTS-1:0]   done, done_nxt;
    logic [DATA_WIDTH-1:0] ram [ELEMENTS];
    logic [POP_WIDTH-1:0]  done_rot;
    logic [PV_W-1:0]       push_ct;
    logic [PC_W-1:0]       pop_ct;
    logic [CMPLT_PORTS-1:0] cmp_ok;
    logic [IDX_W-1:0]      cmp_off;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign count    = tail - head;
    assign free_ct  = PTR_W'(ELEMENTS) - count;

    // Push credit ignores same-cycle retires.
    assign din_ready_ct = (free_ct >= PTR_W'(PUSH_WIDTH)) ? PV_W'(PUSH_WIDTH) : PV_W'(free_ct);

    always_comb begin
        entry_nums = '0;
        for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
            entry_nums[i*IDX_W +: IDX_W] = tail_idx + IDX_W'(i);
        end
    end

    always_comb begin
        dout     = '0;
        done_rot = '0;
        for (int unsigned i = 0; i < POP_WIDTH; i++) begin
            dout[i*DATA_WIDTH +: DATA_WIDTH] = ram[head_idx + IDX_W'(i)];
            done_rot[i]                      = done[head_idx + IDX_W'(i)];
        end
    end

    rob_commit_scan #(
        .POP_WIDTH (POP_WIDTH),
        .IDX_W     (IDX_W)
    ) u_scan (
        .done_rot      (done_rot),
        .count         (count),
        .dout_valid_ct (dout_valid_ct)
    );

`ifdef ROB_FLUSH_EN
    logic [IDX_W-1:0] flush_off;
    logic             flush_hit;
    logic [PTR_W-1:0] keep_ct;

    assign flush_off = flush_entry - head_idx;
    assign flush_hit = flush && ({1'b0, flush_off} < count);
    assign keep_ct   = {1'b0, flush_off} + PTR_W'(1);
`endif

    always_comb begin
        push_ct  = (din_valid_ct < din_ready_ct) ? din_valid_ct : din_ready_ct;
        pop_ct   = (dout_valid_ct < dout_ready_ct) ? dout_valid_ct : dout_ready_ct;
        tail_nxt = tail + PTR_W'(push_ct);
        cmp_ok   = '0;
        cmp_off  = '0;
        for (int unsigned p = 0; p < CMPLT_PORTS; p++) begin
            // Occupancy is judged by distance from the pre-edge head.
            cmp_off   = completed[p*IDX_W +: IDX_W] - head_idx;
            cmp_ok[p] = cmplt_valid[p] && ({1'b0, cmp_off} < count);
`ifdef ROB_FLUSH_EN
            if (flush_hit && ({1'b0, cmp_off} >= keep_ct)) begin
                cmp_ok[p] = 1'b0;
            end
`endif
        end
`ifdef ROB_FLUSH_EN
        if (flush_hit) begin
            push_ct  = '0;
            tail_nxt = head + keep_ct;
            if (PTR_W'(pop_ct) > keep_ct) begin
                pop_ct = PC_W'(keep_ct);
            end
        end
`endif
    end

    // Sets before clears: a completion landing on a retiring entry must not
    // leave a stale done bit behind; pushes always start an entry clean.
    always_comb begin
        done_nxt = done;
        for (int unsigned p = 0; p < CMPLT_PORTS; p++) begin
            if (cmp_ok[p]) begin
                done_nxt[completed[p*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < POP_WIDTH; i++) begin
            if (PC_W'(i) < pop_ct) begin
                done_nxt[head_idx + IDX_W'(i)] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
            if (PV_W'(i) < push_ct) begin
                done_nxt[tail_idx + IDX_W'(i)] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            done <= '0;
        end else begin
            head <= head + PTR_W'(pop_ct);
            tail <= tail_nxt;
            done <= done_nxt;
        end
    end

    // Payload storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
            if (PV_W'(i) < push_ct) begin
                ram[tail_idx + IDX_W'(i)] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_rob_multiport.sv
module tb_rob_multiport;
    localparam int DW   = 11;
    localparam int PW   = 4;
    localparam int POPW = 3;
    localparam int CP   = 3;
    localparam int EL   = 16;
    localparam int IW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [PW*DW-1:0]  din;
    logic [2:0]        din_valid_ct;
    logic [2:0]        din_ready_ct;
    logic [PW*IW-1:0]  entry_nums;
    logic [POPW*DW-1:0] dout;
    logic [2:0]        dout_valid_ct;
    logic [2:0]        dout_ready_ct;
    logic [CP*IW-1:0]  completed;
    logic [CP-1:0]     cmplt_valid;
`ifdef ROB_FLUSH_EN
    logic              flush;
    logic [IW-1:0]     flush_entry;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: unbounded pointers, done flags, payload scoreboard (sb[0] = head).
    int          m_head, m_tail;
    bit          m_done[EL];
    logic [DW-1:0] sb[$];

    rob_multiport #(
        .DATA_WIDTH  (DW),
        .PUSH_WIDTH  (PW),
        .POP_WIDTH   (POPW),
        .CMPLT_PORTS (CP),
        .ELEMENTS    (EL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .din_valid_ct  (din_valid_ct),
        .din_ready_ct  (din_ready_ct),
        .entry_nums    (entry_nums),
        .dout          (dout),
        .dout_valid_ct (dout_valid_ct),
        .dout_ready_ct (dout_ready_ct),
        .completed     (completed),
        .cmplt_valid   (cmplt_valid)
`ifdef ROB_FLUSH_EN
        ,
        .flush         (flush),
        .flush_entry   (flush_entry)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int m_count();
        return m_tail - m_head;
    endfunction

    function automatic int exp_ready();
        int f;
        f = EL - m_count();
        return (f < PW) ? f : PW;
    endfunction

    function automatic int exp_valid();
        int n;
        bit run;
        n = 0;
        run = 1'b1;
        for (int i = 0; i < POPW; i++) begin
            if (run && i < m_count() && m_done[(m_head + i) % EL]) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

    task automatic idle();
        din_valid_ct  = '0;
        dout_ready_ct = '0;
        cmplt_valid   = '0;
        completed     = '0;
`ifdef ROB_FLUSH_EN
        flush         = 1'b0;
        flush_entry   = '0;
`endif
    endtask

    task automatic fill_din();
        for (int i = 0; i < PW; i++) din[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic set_cmp(input int port, input int idx);
        cmplt_valid[port]         = 1'b1;
        completed[port*IW +: IW]  = IW'(idx);
    endtask

    task automatic model_clear();
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < EL; i++) m_done[i] = 1'b0;
        sb.delete();
    endtask

    // Applies one clock edge and advances the model with pre-edge values.
    task automatic tick();
        int k, m, cnt, idx, off;
        cnt = m_count();
        k = (int'(din_valid_ct) < exp_ready()) ? int'(din_valid_ct) : exp_ready();
        m = (exp_valid() < int'(dout_ready_ct)) ? exp_valid() : int'(dout_ready_ct);
        for (int p = 0; p < CP; p++) begin
            if (cmplt_valid[p]) begin
                idx = int'(completed[p*IW +: IW]);
                off = (idx - (m_head % EL) + EL) % EL;
                if (off < cnt) m_done[idx] = 1'b1;
            end
        end
        for (int i = 0; i < k; i++) begin
            sb.push_back(din[i*DW +: DW]);
            m_done[(m_tail + i) % EL] = 1'b0;
        end
        for (int i = 0; i < m; i++) void'(sb.pop_front());
        m_head += m;
        m_tail += k;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        din = '0;
        rst = 1'b0;
        model_clear();
        #3;
        checks++;
        if (din_ready_ct !== 3'd4) begin errors++; $display("FAIL reset_ready: got %0d expected 4", din_ready_ct); end
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", dout_valid_ct); end
        for (int i = 0; i < PW; i++) begin
            checks++;
            if (entry_nums[i*IW +: IW] !== IW'(i)) begin
                errors++; $display("FAIL reset_entry_nums[%0d]: got %0d expected %0d", i, entry_nums[i*IW +: IW], i);
            end
        end
    endtask

    task automatic test_push_order();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < PW; i++) begin
                checks++;
                if (entry_nums[i*IW +: IW] !== IW'(4*b + i)) begin
                    errors++; $display("FAIL push_entry_nums[%0d]: got %0d expected %0d", i, entry_nums[i*IW +: IW], 4*b + i);
                end
            end
            checks++;
            if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL push_valid: got %0d expected 0", dout_valid_ct); end
            fill_din();
            din_valid_ct = 3'd4;
            tick();
        end
        idle();
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL push_valid_end: got %0d expected 0", dout_valid_ct); end
        checks++;
        if (din_ready_ct !== 3'd4) begin errors++; $display("FAIL push_ready_end: got %0d expected 4", din_ready_ct); end
    endtask

    task automatic test_complete_order();
        do_reset();
        fill_din(); din_valid_ct = 3'd4; tick(); idle();
        set_cmp(0, 2); set_cmp(1, 3); tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL cmp_gap: got %0d expected 0", dout_valid_ct); end
        set_cmp(0, 0); tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd1) begin errors++; $display("FAIL cmp_head: got %0d expected 1", dout_valid_ct); end
        set_cmp(2, 1); tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd3) begin errors++; $display("FAIL cmp_cap: got %0d expected 3", dout_valid_ct); end
        dout_ready_ct = 3'd3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout[i*DW +: DW] !== sb[i]) begin errors++; $display("FAIL cmp_dout[%0d]: got %h expected %h", i, dout[i*DW +: DW], sb[i]); end
        end
        tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd1) begin errors++; $display("FAIL cmp_after_pop: got %0d expected 1", dout_valid_ct); end
        checks++;
        if (dout[0 +: DW] !== sb[0]) begin errors++; $display("FAIL cmp_head3_dout: got %h expected %h", dout[0 +: DW], sb[0]); end
        dout_ready_ct = 3'd1; tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL cmp_empty_valid: got %0d expected 0", dout_valid_ct); end
        checks++;
        if (entry_nums[0 +: IW] !== 4'd4) begin errors++; $display("FAIL cmp_empty_tail: got %0d expected 4", entry_nums[0 +: IW]); end
    endtask

    task automatic test_full();
        do_reset();
        repeat (4) begin fill_din(); din_valid_ct = 3'd4; tick(); end
        idle();
        checks++;
        if (din_ready_ct !== 3'd0) begin errors++; $display("FAIL full_ready: got %0d expected 0", din_ready_ct); end
        fill_din(); din_valid_ct = 3'd4; tick(); idle();
        checks++;
        if (entry_nums[0 +: IW] !== 4'd0) begin errors++; $display("FAIL full_tail_hold: got %0d expected 0", entry_nums[0 +: IW]); end
        checks++;
        if (din_ready_ct !== 3'd0) begin errors++; $display("FAIL full_ready_hold: got %0d expected 0", din_ready_ct); end
        set_cmp(0, 0); set_cmp(1, 1); set_cmp(2, 2); tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd3) begin errors++; $display("FAIL full_valid: got %0d expected 3", dout_valid_ct); end
        dout_ready_ct = 3'd3; fill_din(); din_valid_ct = 3'd4;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout[i*DW +: DW] !== sb[i]) begin errors++; $display("FAIL full_dout[%0d]: got %h expected %h", i, dout[i*DW +: DW], sb[i]); end
        end
        tick(); idle();
        checks++;
        if (din_ready_ct !== 3'd3) begin errors++; $display("FAIL full_ready_after_pop: got %0d expected 3", din_ready_ct); end
        checks++;
        if (entry_nums[0 +: IW] !== 4'd0) begin errors++; $display("FAIL full_no_push: got %0d expected 0", entry_nums[0 +: IW]); end
        fill_din(); din_valid_ct = 3'd3; tick(); idle();
        checks++;
        if (din_ready_ct !== 3'd0) begin errors++; $display("FAIL full_refill: got %0d expected 0", din_ready_ct); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int j = 0; j < 7; j++) begin
            fill_din(); din_valid_ct = 3'd2; tick(); idle();
            set_cmp(0, 2*j); set_cmp(1, 2*j + 1); tick(); idle();
            checks++;
            if (dout_valid_ct !== 3'd2) begin errors++; $display("FAIL wrap_prep_valid: got %0d expected 2", dout_valid_ct); end
            dout_ready_ct = 3'd2;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dout[i*DW +: DW] !== sb[i]) begin errors++; $display("FAIL wrap_prep_dout[%0d]: got %h expected %h", i, dout[i*DW +: DW], sb[i]); end
            end
            tick(); idle();
        end
        for (int i = 0; i < PW; i++) begin
            checks++;
            if (entry_nums[i*IW +: IW] !== IW'((14 + i) % EL)) begin
                errors++; $display("FAIL wrap_entry_nums[%0d]: got %0d expected %0d", i, entry_nums[i*IW +: IW], (14 + i) % EL);
            end
        end
        fill_din(); din_valid_ct = 3'd4; tick(); idle();
        set_cmp(0, 14); set_cmp(1, 15); set_cmp(2, 0); tick(); idle();
        set_cmp(1, 1); tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd3) begin errors++; $display("FAIL wrap_valid: got %0d expected 3", dout_valid_ct); end
        dout_ready_ct = 3'd3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout[i*DW +: DW] !== sb[i]) begin errors++; $display("FAIL wrap_dout[%0d]: got %h expected %h", i, dout[i*DW +: DW], sb[i]); end
        end
        tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd1) begin errors++; $display("FAIL wrap_last_valid: got %0d expected 1", dout_valid_ct); end
        checks++;
        if (dout[0 +: DW] !== sb[0]) begin errors++; $display("FAIL wrap_last_dout: got %h expected %h", dout[0 +: DW], sb[0]); end
        dout_ready_ct = 3'd3; tick(); idle();
        checks++;
        if (din_ready_ct !== 3'd4) begin errors++; $display("FAIL wrap_empty_ready: got %0d expected 4", din_ready_ct); end
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL wrap_empty_valid: got %0d expected 0", dout_valid_ct); end
        checks++;
        if (entry_nums[0 +: IW] !== 4'd2) begin errors++; $display("FAIL wrap_tail: got %0d expected 2", entry_nums[0 +: IW]); end
    endtask

    task automatic test_unoccupied();
        do_reset();
        fill_din(); din_valid_ct = 3'd4; tick(); idle();
        set_cmp(2, 9); tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL unocc_valid: got %0d expected 0", dout_valid_ct); end
        fill_din(); din_valid_ct = 3'd4; tick();
        fill_din(); din_valid_ct = 3'd4; tick(); idle();
        for (int c = 0; c < 9; c += 3) begin
            set_cmp(0, c); set_cmp(1, c + 1); set_cmp(2, c + 2); tick(); idle();
        end
        set_cmp(0, 10); set_cmp(1, 11); tick(); idle();
        repeat (3) begin
            checks++;
            if (dout_valid_ct !== 3'd3) begin errors++; $display("FAIL unocc_run: got %0d expected 3", dout_valid_ct); end
            dout_ready_ct = 3'd3;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dout[i*DW +: DW] !== sb[i]) begin errors++; $display("FAIL unocc_dout[%0d]: got %h expected %h", i, dout[i*DW +: DW], sb[i]); end
            end
            tick(); idle();
        end
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL unocc_stop9: got %0d expected 0", dout_valid_ct); end
        set_cmp(0, 9); tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd3) begin errors++; $display("FAIL unocc_resume: got %0d expected 3", dout_valid_ct); end
    endtask

    task automatic test_back_to_back();
        int cnt, m;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            checks++;
            if (int'(din_ready_ct) != exp_ready()) begin errors++; $display("FAIL b2b_ready: got %0d expected %0d", din_ready_ct, exp_ready()); end
            checks++;
            if (int'(dout_valid_ct) != exp_valid()) begin errors++; $display("FAIL b2b_valid: got %0d expected %0d", dout_valid_ct, exp_valid()); end
            for (int i = 0; i < PW; i++) begin
                checks++;
                if (entry_nums[i*IW +: IW] !== IW'((m_tail + i) % EL)) begin
                    errors++; $display("FAIL b2b_entry_nums[%0d]: got %0d expected %0d", i, entry_nums[i*IW +: IW], (m_tail + i) % EL);
                end
            end
            idle();
            fill_din();
            din_valid_ct  = 3'($urandom_range(0, 4));
            dout_ready_ct = 3'($urandom_range(0, 3));
            cnt = m_count();
            for (int p = 0; p < CP; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (cnt > 0) set_cmp(p, (m_head + int'($urandom_range(0, cnt - 1))) % EL);
                    else         set_cmp(p, int'($urandom_range(0, EL - 1)));
                end
            end
            m = (exp_valid() < int'(dout_ready_ct)) ? exp_valid() : int'(dout_ready_ct);
            for (int i = 0; i < m; i++) begin
                checks++;
                if (dout[i*DW +: DW] !== sb[i]) begin errors++; $display("FAIL b2b_dout[%0d]: got %h expected %h", i, dout[i*DW +: DW], sb[i]); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_din(); din_valid_ct = 3'd4; tick();
        fill_din(); din_valid_ct = 3'd4; set_cmp(0, 0); tick(); idle();
        set_cmp(0, 1); tick(); idle();
        rst = 1'b0;
        #1;
        model_clear();
        checks++;
        if (din_ready_ct !== 3'd4) begin errors++; $display("FAIL rstmid_ready: got %0d expected 4", din_ready_ct); end
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL rstmid_valid: got %0d expected 0", dout_valid_ct); end
        for (int i = 0; i < PW; i++) begin
            checks++;
            if (entry_nums[i*IW +: IW] !== IW'(i)) begin
                errors++; $display("FAIL rstmid_entry_nums[%0d]: got %0d expected %0d", i, entry_nums[i*IW +: IW], i);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        fill_din(); din_valid_ct = 3'd4; tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL rstmid_done_cleared: got %0d expected 0", dout_valid_ct); end
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        do_reset();
        fill_din(); din_valid_ct = 3'd4; tick();
        fill_din(); din_valid_ct = 3'd4; tick(); idle();
        flush = 1'b1; flush_entry = 4'd3; fill_din(); din_valid_ct = 3'd2;
        @(posedge clk); #1;
        idle();
        m_tail = 4;
        while (sb.size() > 4) void'(sb.pop_back());
        checks++;
        if (entry_nums[0 +: IW] !== 4'd4) begin errors++; $display("FAIL flush_tail: got %0d expected 4", entry_nums[0 +: IW]); end
        checks++;
        if (din_ready_ct !== 3'd4) begin errors++; $display("FAIL flush_ready: got %0d expected 4", din_ready_ct); end
        flush = 1'b1; flush_entry = 4'd9; tick(); idle();
        checks++;
        if (entry_nums[0 +: IW] !== 4'd4) begin errors++; $display("FAIL flush_ignored: got %0d expected 4", entry_nums[0 +: IW]); end
        set_cmp(0, 0); set_cmp(1, 1); set_cmp(2, 2); tick(); idle();
        checks++;
        if (dout_valid_ct !== 3'd3) begin errors++; $display("FAIL flush_valid: got %0d expected 3", dout_valid_ct); end
        flush = 1'b1; flush_entry = 4'd0; dout_ready_ct = 3'd3;
        checks++;
        if (dout[0 +: DW] !== sb[0]) begin errors++; $display("FAIL flush_clip_dout: got %h expected %h", dout[0 +: DW], sb[0]); end
        @(posedge clk); #1;
        idle();
        model_clear();
        m_head = 1; m_tail = 1;
        checks++;
        if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL flush_clip_valid: got %0d expected 0", dout_valid_ct); end
        checks++;
        if (din_ready_ct !== 3'd4) begin errors++; $display("FAIL flush_clip_ready: got %0d expected 4", din_ready_ct); end
        checks++;
        if (entry_nums[0 +: IW] !== 4'd1) begin errors++; $display("FAIL flush_clip_tail: got %0d expected 1", entry_nums[0 +: IW]); end
    endtask
`endif

    initial begin
        din = '0;
        test_reset();
        test_push_order();
        test_complete_order();
        test_full();
        test_wrap();
        test_unoccupied();
        test_back_to_back();
        test_reset_mid();
`ifdef ROB_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised successor to the core's fixed 4-push/3-complete reorder buffer.
- Sits between the frontend rename stage and the commit/free-list path: allocates entries in program order, records out-of-order completions, retires completed entries in order.
- New over the current ROB:
  - configurable push, pop and completion port counts;
  - count-based allocation and retire handshakes;
  - cumulative completion-run scan;
  - optional tail-squash (flush) for terminator mispredicts.

Parameters:
- DATA_WIDTH, 11: payload bits per entry (old-alias pair plus valid bit, 2*`PR_ADDR_W+1).
- PUSH_WIDTH, 4: maximum entries allocated per cycle.
- POP_WIDTH, 3: maximum entries retired per cycle.
- CMPLT_PORTS, 3: completion report ports (arith, mem, term).
- ELEMENTS, 16: entry count. Must be a power of two and at least max(PUSH_WIDTH, POP_WIDTH).
- IDX_W, $clog2(ELEMENTS): entry index width. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- din  in  PUSH_WIDTH*DATA_WIDTH  payload lanes, lane 0 oldest.
- din_valid_ct  in  $clog2(PUSH_WIDTH)+1  lanes 0..n-1 valid.
- din_ready_ct  out  $clog2(PUSH_WIDTH)+1  min(PUSH_WIDTH, free entries).
- entry_nums  out  PUSH_WIDTH*IDX_W  index lane i would receive if pushed this cycle.
- dout  out  POP_WIDTH*DATA_WIDTH  retiring payloads, lane 0 oldest.
- dout_valid_ct  out  $clog2(POP_WIDTH)+1  consecutive completed entries from head, capped at POP_WIDTH.
- dout_ready_ct  in  $clog2(POP_WIDTH)+1  consumer capacity this cycle.
- completed  in  CMPLT_PORTS*IDX_W  completing entry indices.
- cmplt_valid  in  CMPLT_PORTS  per-port completion strobe.
- flush  in  1  squash request (ROB_FLUSH_EN only).
- flush_entry  in  IDX_W  last surviving entry (ROB_FLUSH_EN only).

Behaviour:
- State:
  - head and tail, each IDX_W+1 bits including a wrap bit;
  - payload RAM, ELEMENTS x DATA_WIDTH;
  - done bit per entry.
- Occupancy: count = tail - head, range 0..ELEMENTS. Empty when count=0; full when count=ELEMENTS.
- Reset (rst low, asynchronous):
  - head=tail=0, all done bits 0. Payload RAM is not reset.
  - Outputs while in reset: din_ready_ct=PUSH_WIDTH, dout_valid_ct=0, entry_nums={0..PUSH_WIDTH-1}.
  - Reset mid-operation discards all entries immediately.
- Push:
  - k = min(din_valid_ct, din_ready_ct).
  - Lane i<k writes payload at (tail+i) mod ELEMENTS and clears that entry's done bit.
  - tail += k.
  - din_valid_ct above din_ready_ct is not an error; excess lanes are dropped and the producer retries.
- entry_nums and din_ready_ct: combinational from registered head/tail only.
  - Same-cycle pops do not add push credit.
- Complete:
  - Each valid port sets done[completed] at the clock edge.
  - Duplicate indices across ports are harmless.
  - Completions to unoccupied indices are ignored; occupancy is tested against pre-edge head/tail.
- Retire:
  - dout lane i = payload[(head+i) mod ELEMENTS].
  - dout_valid_ct = length of the run of set done bits starting at head, limited by count and POP_WIDTH.
  - m = min(dout_valid_ct, dout_ready_ct); head += m; retired done bits cleared.
- Latency:
  - Completion at edge t is visible in dout_valid_ct after edge t (no bypass).
  - A push at edge t can complete at t+1 and retire at t+2 at earliest.
- Simultaneous events:
  - Push, complete and retire in the same cycle are all applied.
  - A push cannot target an occupied index, so it never collides with a completion.
  - Full with retire in the same cycle: no push that cycle.
- Wrap-around: index arithmetic is mod ELEMENTS; the wrap bit distinguishes full from empty.

Optional Feature:
- ROB_FLUSH_EN defined:
  - flush and flush_entry ports exist.
  - When flush=1 and flush_entry is occupied, at the edge tail <= head + ((flush_entry-head) mod ELEMENTS) + 1.
  - Pushes that cycle are dropped.
  - Completions to squashed entries that cycle are ignored.
  - Retire proceeds normally; if a retire would pass the new tail it is clipped to it.
  - flush with an unoccupied flush_entry is ignored.
- ROB_FLUSH_EN undefined: no flush ports; only reset clears the buffer.

Decomposition:
- Shared header: `PR_ADDR_W and `ROB_DATA_W (2*`PR_ADDR_W+1), plus the default ELEMENTS, PUSH_WIDTH and POP_WIDTH as `defines for the core top level.
- One sub-module, rob_commit_scan:
  - inputs: done bits rotated to head, count;
  - output: dout_valid_ct (leading-ones count capped at POP_WIDTH).

Test Plan:
- Reset, push 4 (din_valid_ct=4), no completes -> entry_nums advance 0..3 then 4..7; dout_valid_ct=0 throughout.
- Push 4 into entries 0..3; complete 2 and 3 -> dout_valid_ct=0. Complete 0 -> next cycle dout_valid_ct=1. Complete 1 -> dout_valid_ct=3 (POP_WIDTH cap); with dout_ready_ct=3, head=3.
- Fill to 16 -> din_ready_ct=0. Push with din_valid_ct=4 -> tail unchanged. Retire 3 -> din_ready_ct=3 the next cycle.
- Wrap: head=14, push 4 -> entry_nums 14,15,0,1. Complete all, then retire 3 then 1 -> empty; head=tail=18 (wrap bit set).
- Completion to unoccupied entry 9 while head=0, tail=4 -> no effect; a later push into 9 starts with done=0.
- ROB_FLUSH_EN: entries 0..7 occupied, flush_entry=3 with a concurrent push of 2 -> tail=4, push dropped, entry_nums next cycle start at 4.
